// File: rtl/nibble_serial_adder_if.sv
// Handshake bundle for nibble_serial_adder: operand side (in_*, A, B, Cin)
// and result side (out_*, Sum, Cout, Ovf). The master drives operands and
// out_ready; the slave (the adder) drives results and in_ready.
interface nibble_serial_adder_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] Sum;
   logic         Cout;
   logic         Ovf;

   modport master (
      output in_valid, A, B, Cin, out_ready,
      input  in_ready, out_valid, Sum, Cout, Ovf
   );

   modport slave (
      input  in_valid, A, B, Cin, out_ready,
      output in_ready, out_valid, Sum, Cout, Ovf
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-word adder built around one 4-bit full-adder stage. Operands are
// latched on acceptance, then one nibble is summed per clock (LSB nibble
// first) with the carry held in a register between cycles. The result,
// carry out and signed overflow are presented with a valid/ready handshake.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   nibble_serial_adder_if.slave bus
);
   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [W-1:0]     sum_q;
   logic             carry_q;
   logic             cout_q;
   logic             ovf_q;
   logic             out_valid_q;
   logic [IDX_W-1:0] idx;

   // Nibble-stage signals
   logic [W-1:0]     a_shift;
   logic [W-1:0]     b_shift;
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       low_sum;   // {carry into bit 3, sum bits 2:0}
   logic [1:0]       high_sum;  // {stage carry out, sum bit 3}
   logic [3:0]       nib_sum;
   logic             nib_c3;
   logic             nib_cout;
   logic [W-1:0]     sum_merge;

   // 4-bit full-adder stage fed from the current nibble of the operands
   always_comb begin
      // NOTE: every signal gets a value on every path here, so no latches form.
      a_shift   = a_q >> {idx, 2'b00};
      b_shift   = b_q >> {idx, 2'b00};
      nib_a     = a_shift[3:0];
      nib_b     = b_shift[3:0];
      // Split at bit 3 so the carry into the nibble's MSB is visible for Ovf.
      low_sum   = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b000, carry_q};
      nib_c3    = low_sum[3];
      high_sum  = {1'b0, nib_a[3]} + {1'b0, nib_b[3]} + {1'b0, nib_c3};
      nib_cout  = high_sum[1];
      nib_sum   = {high_sum[0], low_sum[2:0]};
      // Sum register is cleared on accept, so OR-ing each nibble in is exact.
      sum_merge = sum_q | (W'(nib_sum) << {idx, 2'b00});
   end

   // Control FSM plus operand, carry and result registers
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: operand registers are reset along with everything else; they are
      // a handful of flops, not a memory array, and this keeps outputs clean.
      if (rst) begin
         state       <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         idx         <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // sees the pre-edge value of every other register.
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.A;
                  b_q     <= bus.B;
                  carry_q <= bus.Cin;
                  sum_q   <= '0;
                  idx     <= '0;
                  state   <= S_RUN;
               end
            end

            S_RUN: begin
               sum_q   <= sum_merge;
               carry_q <= nib_cout;
               if (idx == LAST_IDX) begin
                  cout_q      <= nib_cout;
                  ovf_q       <= nib_c3 ^ nib_cout;
                  out_valid_q <= 1'b1;
                  idx         <= '0;
                  state       <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            S_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= S_IDLE;
               end
            end

            default: begin
               out_valid_q <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

   // in_ready is a pure decode of the state register; no input reaches an output.
   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.Sum       = sum_q;
   assign bus.Cout      = cout_q;
   assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder. Two instances: the default
// 4-nibble build (directed cases, backpressure, reset mid-run, random ops)
// and a 1-nibble build driven through every {Cin, A, B} combination.
// Drivers push expected results into queues; monitors pop and compare.
module tb_nibble_serial_adder;
   localparam int N4 = 4;
   localparam int W4 = 16;
   localparam int N1 = 1;
   localparam int W1 = 4;

   typedef struct {
      longint sum;
      logic   cout;
      logic   ovf;
      longint acc;   // cycle stamp of the accept cycle
   } exp_t;

   logic   clk = 1'b0;
   logic   rst;
   logic   rst1;
   longint cyc = 0;
   int     n_cmp = 0;
   int     n_bad = 0;
   int     ready_mode = 1;   // 0: out_ready low, 1: high, 2: random
   logic   done1 = 1'b0;
   exp_t   q4[$];
   exp_t   q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nibble_serial_adder_if #(.NIBBLES(N4)) bus4 ();
   nibble_serial_adder_if #(.NIBBLES(N1)) bus1 ();

   nibble_serial_adder #(.NIBBLES(N4)) dut4 (.clk(clk), .rst(rst),  .bus(bus4));
   nibble_serial_adder #(.NIBBLES(N1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: plain unsigned sum for {Cout,Sum}; overflow from the signed
   // interpretation of the operands leaving the representable range.
   function automatic exp_t model(input longint a, input longint b, input logic cin, input int w);
      exp_t   e;
      longint total, half, sa, sb, ss;
      total  = a + b + longint'(cin);
      e.sum  = total % (longint'(1) << w);
      e.cout = (total >> w) != 0;
      half   = longint'(1) << (w - 1);
      sa     = (a >= half) ? a - 2 * half : a;
      sb     = (b >= half) ? b - 2 * half : b;
      ss     = sa + sb + longint'(cin);
      e.ovf  = (ss >= half) || (ss < -half);
      e.acc  = 0;
      return e;
   endfunction

   function automatic exp_t mk(input longint s, input logic c, input logic o);
      exp_t e;
      e.sum = s; e.cout = c; e.ovf = o; e.acc = 0;
      return e;
   endfunction

   // Called just after a rising edge. Returns just after the accept edge,
   // with A/B/Cin scrambled to show operands were latched.
   task automatic send4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic cin, input exp_t e);
      int budget = 0;
      bus4.A = a; bus4.B = b; bus4.Cin = cin; bus4.in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && bus4.in_ready) break;
         budget++;
         if (budget > 200) begin
            check("dut4_accept_timeout", 1, 0);
            bus4.in_valid = 1'b0;
            return;
         end
      end
      e.acc = cyc;
      q4.push_back(e);
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      bus4.A = W4'($urandom); bus4.B = W4'($urandom); bus4.Cin = 1'($urandom);
   endtask

   task automatic send1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic cin, input exp_t e);
      int budget = 0;
      bus1.A = a; bus1.B = b; bus1.Cin = cin; bus1.in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus1.in_ready) break;
         budget++;
         if (budget > 200) begin
            check("dut1_accept_timeout", 1, 0);
            bus1.in_valid = 1'b0;
            return;
         end
      end
      e.acc = cyc;
      q1.push_back(e);
      @(posedge clk);
      #1;
      bus1.in_valid = 1'b0;
      bus1.A = W1'($urandom); bus1.B = W1'($urandom); bus1.Cin = 1'($urandom);
   endtask

   task automatic wait_drain4();
      int budget = 0;
      while (q4.size() != 0 && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      check("dut4_drain", q4.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // out_ready driver for the 4-nibble instance
   initial begin
      bus4.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus4.out_ready = 1'b0;
            1:       bus4.out_ready = 1'b1;
            default: bus4.out_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // Monitor for the 4-nibble instance: new result, hold stability, handshake
   initial begin
      logic        prev;
      logic [17:0] held;
      exp_t        e;
      prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0;
         end else if (bus4.out_valid) begin
            if (!prev) begin
               if (q4.size() == 0) begin
                  check("dut4_spurious_out_valid", 1, 0);
               end else begin
                  e = q4[0];
                  check("dut4_latency", cyc - e.acc, N4 + 1);
                  check("dut4_sum",  bus4.Sum,  e.sum);
                  check("dut4_cout", bus4.Cout, e.cout);
                  check("dut4_ovf",  bus4.Ovf,  e.ovf);
               end
               held = {bus4.Sum, bus4.Cout, bus4.Ovf};
            end else begin
               check("dut4_hold_stable", {bus4.Sum, bus4.Cout, bus4.Ovf}, held);
            end
            check("dut4_in_ready_in_done", bus4.in_ready, 0);
            if (bus4.out_ready) begin
               if (q4.size() > 0) void'(q4.pop_front());
               prev = 1'b0;
            end else begin
               prev = 1'b1;
            end
         end else begin
            prev = 1'b0;
         end
      end
   end

   // Monitor for the 1-nibble instance (out_ready tied high)
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst1 && bus1.out_valid) begin
            if (q1.size() == 0) begin
               check("dut1_spurious_out_valid", 1, 0);
            end else begin
               e = q1.pop_front();
               check("dut1_latency", cyc - e.acc, N1 + 1);
               check("dut1_sum",  bus1.Sum,  e.sum);
               check("dut1_cout", bus1.Cout, e.cout);
               check("dut1_ovf",  bus1.Ovf,  e.ovf);
            end
         end
      end
   end

   // Exhaustive driver for the 1-nibble instance
   initial begin
      bus1.in_valid = 1'b0; bus1.A = '0; bus1.B = '0; bus1.Cin = 1'b0;
      bus1.out_ready = 1'b1;
      rst1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst1 = 1'b0;
      for (int c = 0; c < 2; c++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               send1(W1'(a), W1'(b), 1'(c), model(longint'(a), longint'(b), 1'(c), W1));
      done1 = 1'b1;
   end

   // Watchdog
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Main sequence for the 4-nibble instance
   initial begin
      logic [W4-1:0] ra, rb;
      logic          rc;
      int            budget;

      bus4.in_valid = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Cin = 1'b0;
      rst = 1'b1;
      #2;
      check("reset_out_valid", bus4.out_valid, 0);
      check("reset_sum",       bus4.Sum,       0);
      check("reset_cout",      bus4.Cout,      0);
      check("reset_ovf",       bus4.Ovf,       0);
      check("reset_in_ready",  bus4.in_ready,  1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic arithmetic corners
      send4(16'h0000, 16'h0000, 1'b0, mk(16'h0000, 1'b0, 1'b0));
      send4(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
      send4(16'h7FFF, 16'h0000, 1'b1, mk(16'h8000, 1'b0, 1'b1));
      send4(16'h8000, 16'h8000, 1'b0, mk(16'h0000, 1'b1, 1'b1));

      // Backpressure, ignored in_valid during RUN, accept right after handshake
      wait_drain4();
      ready_mode = 0;
      send4(16'h1234, 16'h4321, 1'b0, mk(16'h5555, 1'b0, 1'b0));
      bus4.A = 16'hFFFF; bus4.B = 16'hFFFF; bus4.in_valid = 1'b1;
      @(negedge clk);
      check("run_in_ready", bus4.in_ready, 0);
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      budget = 0;
      do begin
         @(negedge clk);
         budget++;
      end while (!bus4.out_valid && budget < 50);
      check("bp_valid_seen", bus4.out_valid, 1);
      repeat (6) begin
         @(negedge clk);
         check("bp_out_valid", bus4.out_valid, 1);
         check("bp_sum",       bus4.Sum,       16'h5555);
         check("bp_in_ready",  bus4.in_ready,  0);
      end
      ready_mode = 1;
      budget = 0;
      do begin
         @(negedge clk);
         budget++;
      end while (bus4.out_valid && budget < 50);
      check("post_handshake_in_ready", bus4.in_ready, 1);
      @(posedge clk);
      #1;

      // Reset in the second RUN cycle drops the operation
      send4(16'hABCD, 16'h1111, 1'b0, model(64'hABCD, 64'h1111, 1'b0, W4));
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrun_rst_out_valid", bus4.out_valid, 0);
      check("midrun_rst_sum",       bus4.Sum,       0);
      check("midrun_rst_cout",      bus4.Cout,      0);
      check("midrun_rst_ovf",       bus4.Ovf,       0);
      check("midrun_rst_in_ready",  bus4.in_ready,  1);
      q4.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("after_rst_in_ready",  bus4.in_ready,  1);
      check("after_rst_out_valid", bus4.out_valid, 0);
      @(posedge clk);
      #1;
      send4(16'h0F0F, 16'h00F1, 1'b1, mk(16'h1001, 1'b0, 1'b0));

      // Randomised traffic with random gaps and random out_ready
      wait_drain4();
      ready_mode = 2;
      for (int i = 0; i < 2000; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         ra = W4'($urandom);
         rb = W4'($urandom);
         rc = 1'($urandom);
         send4(ra, rb, rc, model(longint'(ra), longint'(rb), rc, W4));
      end
      ready_mode = 1;
      wait_drain4();

      budget = 0;
      while ((!done1 || q1.size() != 0) && budget < 20000) begin
         @(negedge clk);
         budget++;
      end
      check("dut1_done", done1, 1);
      check("dut1_drain", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-word adder that computes a W-bit sum by driving a single 4-bit full-adder stage (A, B, Cin → Sum, Cout) one nibble per clock, LSB nibble first, with the carry held in a register between cycles. It sits directly upstream of the 4-bit adder datapath, sequences operands into it and collects its results. It presents valid/ready handshakes on both sides so it can be dropped between a register-file read and a writeback stage.

## Interface
- NIBBLES, 4, operand width in nibbles; W = 4*NIBBLES; legal range 1..16
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- A  input  W  addend A
- B  input  W  addend B
- Cin  input  1  carry into nibble 0
- out_valid  output  1  Sum/Cout/Ovf valid
- out_ready  input  1  consumer accepts result
- Sum  output  W  registered sum
- Cout  output  1  carry out of the MSB nibble
- Ovf  output  1  signed overflow: carry into bit W-1 XOR Cout

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; Sum=0, Cout=0, Ovf=0, out_valid=0, nibble index=0, carry register=0.
- IDLE: in_ready=1. On in_valid&in_ready: latch A, B into operand registers; carry register←Cin; Sum register←0; index←0; → RUN.
- RUN: in_ready=0, out_valid=0. Each cycle, feed A[4i+3:4i], B[4i+3:4i] and the carry register to the 4-bit add stage; write its 4-bit Sum to Sum[4i+3:4i]; carry register←stage Cout; index←index+1. On the cycle with index=NIBBLES-1, also capture Ovf = (carry into bit 3 of that nibble) XOR stage Cout, and Cout = stage Cout; → DONE.
- DONE: out_valid=1; Sum, Cout, Ovf held stable. On out_ready → IDLE (out_valid drops next cycle). No new operand is accepted in DONE.
- in_valid while in RUN/DONE is ignored; the upstream must hold until in_ready.
- Input A/B changing after acceptance has no effect (operands latched).
- Arithmetic: {Cout, Sum} = A + B + Cin, unsigned, exact modulo 2^(W+1).
- Sum register contents during RUN are partial and undefined for consumers; only meaningful while out_valid=1.
- NIBBLES=1: RUN lasts one cycle; behaviour otherwise identical.

## Timing
- Accept edge at cycle t (in_valid&in_ready sampled high) → RUN during cycles t+1..t+NIBBLES → out_valid=1 from cycle t+NIBBLES+1.
- Latency accept→out_valid: NIBBLES+1 cycles (5 for default).
- Minimum issue interval with out_ready tied high: NIBBLES+2 cycles (IDLE, NIBBLES×RUN, DONE).
- out_valid, Sum, Cout, Ovf, in_ready are registered state (in_ready decoded from state register only; no combinational path from any input to any output).
- Backpressure: out_ready low holds DONE indefinitely with all outputs stable.
- rst asserted at any time (including mid-RUN or in DONE with out_valid=1): immediately clears all state and outputs to reset values; the in-flight operation is dropped; first accept possible on the first rising edge after rst deasserts.

## Test plan
- A=0x0000, B=0x0000, Cin=0 → out_valid exactly 5 cycles after accept; Sum=0x0000, Cout=0, Ovf=0.
- A=0xFFFF, B=0x0001, Cin=0 → Sum=0x0000, Cout=1, Ovf=0 (full carry ripple across all four nibbles).
- A=0x7FFF, B=0x0000, Cin=1 → Sum=0x8000, Cout=0, Ovf=1; then A=0x8000, B=0x8000, Cin=0 → Sum=0x0000, Cout=1, Ovf=1.
- A=0x1234, B=0x4321, Cin=0 with out_ready low for 6 cycles after out_valid → Sum=0x5555 held stable, in_ready=0 throughout; second in_valid pulse during RUN ignored; accept resumes one cycle after handshake.
- Accept A=0xABCD, B=0x1111, assert rst for 1 cycle on the 2nd RUN cycle → all outputs 0, state IDLE; next op A=0x0F0F, B=0x00F1, Cin=1 → Sum=0x1001, Cout=0, Ovf=0.
- Randomised 2000 ops with random out_ready/in_valid gaps, plus NIBBLES=1 build with all 512 {Cin,A,B} combinations → every result matches A+B+Cin model; no out_valid without prior accept.
